// File: rtl/ex_div_if.sv
// Operand, control and result bundle between the EX stage and the multi-cycle divider.
interface ex_div_if #(
    parameter int unsigned WIDTH = 32
);
    logic                 signed_div_i;
    logic [WIDTH-1:0]     opdata1_i;
    logic [WIDTH-1:0]     opdata2_i;
    logic                 start_i;
    logic                 annul_i;
    logic [2*WIDTH-1:0]   result_o;
    logic                 ready_o;
    logic                 stallreq_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o, stallreq_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o, stallreq_o
    );
endinterface

// File: rtl/ex_div.sv
// Restoring radix-2 divider for DIV/DIVU: one quotient bit per cycle, result is {remainder, quotient}.
module ex_div #(
    parameter int unsigned WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    ex_div_if.slave  div
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_DIVZERO, S_ON, S_END} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     r_q, r_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic [WIDTH-1:0]     d_q, d_d;
    logic                 neg_quo_q, neg_quo_d;
    logic                 neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0]   result_q, result_d;

    logic                 op1_neg, op2_neg;
    logic [WIDTH:0]       shifted;
    logic                 step_ge;
    logic [WIDTH-1:0]     step_r, step_q;

    assign op1_neg = div.signed_div_i & div.opdata1_i[WIDTH-1];
    assign op2_neg = div.signed_div_i & div.opdata2_i[WIDTH-1];

    // The partial remainder never reaches the divisor, so WIDTH bits hold it between steps.
    assign shifted = {r_q, q_q[WIDTH-1]};
    assign step_ge = (shifted >= {1'b0, d_q});
    assign step_r  = step_ge ? WIDTH'(shifted - {1'b0, d_q}) : WIDTH'(shifted);
    assign step_q  = {q_q[WIDTH-2:0], step_ge};

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        r_d       = r_q;
        q_d       = q_q;
        d_d       = d_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        case (state_q)
            S_IDLE: begin
                if (div.start_i && !div.annul_i) begin
                    if (div.opdata2_i == '0) begin
                        state_d = S_DIVZERO;
                    end else begin
                        state_d   = S_ON;
                        cnt_d     = '0;
                        r_d       = '0;
                        q_d       = op1_neg ? WIDTH'(-div.opdata1_i) : div.opdata1_i;
                        d_d       = op2_neg ? WIDTH'(-div.opdata2_i) : div.opdata2_i;
                        neg_quo_d = op1_neg ^ op2_neg;
                        neg_rem_d = op1_neg;
                    end
                end
            end
            S_DIVZERO: begin
                if (div.annul_i) begin
                    state_d = S_IDLE;
                end else begin
                    result_d = '0;
                    state_d  = S_END;
                end
            end
            S_ON: begin
                if (div.annul_i) begin
                    state_d = S_IDLE;
                end else begin
                    r_d   = step_r;
                    q_d   = step_q;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d  = S_END;
                        result_d = {neg_rem_q ? WIDTH'(-step_r) : step_r,
                                    neg_quo_q ? WIDTH'(-step_q) : step_q};
                    end
                end
            end
            S_END:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            r_q       <= '0;
            q_q       <= '0;
            d_q       <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            r_q       <= r_d;
            q_q       <= q_d;
            d_q       <= d_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

    assign div.result_o   = result_q;
    assign div.ready_o    = (state_q == S_END);
    assign div.stallreq_o = div.start_i & ~div.ready_o & ~div.annul_i;

endmodule

// File: tb/tb_ex_div.sv
// Directed bench for ex_div: unsigned, signed, divide-by-zero, annul, back-to-back, reset and overflow.
module tb_ex_div;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    ex_div_if #(.WIDTH(32)) bus ();

    ex_div #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .div (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge; a new cycle starts here.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Issue one divide at the current cycle (cycle 0), hold start until ready or timeout.
    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          output logic [63:0] res, output int rcyc, output int scnt);
        int cyc;
        bus.signed_div_i = sgn;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.start_i      = 1'b1;
        rcyc = -1;
        scnt = 0;
        res  = '0;
        cyc  = 0;
        while (cyc < 100) begin
            #1;
            if (bus.stallreq_o) scnt++;
            if (bus.ready_o) begin
                rcyc = cyc;
                res  = bus.result_o;
                break;
            end
            next_cycle();
            cyc++;
        end
        bus.start_i = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (bus.ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", bus.ready_o); end
        total++;
        if (bus.result_o !== 64'd0) begin bad++; $display("FAIL reset_result got=%h exp=0", bus.result_o); end
        total++;
        if (bus.stallreq_o !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", bus.stallreq_o); end
    endtask

    task automatic test_unsigned();
        logic [63:0] res;
        int rc, sc;
        do_div(1'b0, 32'd100, 32'd7, res, rc, sc);
        total++;
        if (rc !== 33) begin bad++; $display("FAIL divu_ready_cycle got=%0d exp=33", rc); end
        total++;
        if (sc !== 33) begin bad++; $display("FAIL divu_stall_cycles got=%0d exp=33", sc); end
        total++;
        if (res !== {32'd2, 32'd14}) begin bad++; $display("FAIL divu_result got=%h exp=%h", res, {32'd2, 32'd14}); end
        #1;
        total++;
        if (bus.ready_o !== 1'b0) begin bad++; $display("FAIL divu_ready_after got=%b exp=0", bus.ready_o); end
        total++;
        if (bus.result_o !== {32'd2, 32'd14}) begin bad++; $display("FAIL divu_result_hold got=%h", bus.result_o); end
    endtask

    task automatic test_signed();
        logic [63:0] res;
        int rc, sc;
        next_cycle();
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2, res, rc, sc);
        total++;
        if (res !== {32'hFFFF_FFFF, 32'hFFFF_FFFD} || rc !== 33) begin
            bad++; $display("FAIL div_m7_2 got=%h cyc=%0d exp=ffffffff_fffffffd cyc=33", res, rc);
        end
        do_div(1'b1, 32'd7, 32'hFFFF_FFFE, res, rc, sc);
        total++;
        if (res !== {32'h0000_0001, 32'hFFFF_FFFD} || rc !== 33) begin
            bad++; $display("FAIL div_7_m2 got=%h cyc=%0d exp=00000001_fffffffd cyc=33", res, rc);
        end
        do_div(1'b0, 32'hFFFF_FFFF, 32'd1, res, rc, sc);
        total++;
        if (res !== {32'h0, 32'hFFFF_FFFF} || rc !== 33) begin
            bad++; $display("FAIL divu_max_1 got=%h cyc=%0d exp=00000000_ffffffff cyc=33", res, rc);
        end
    endtask

    task automatic test_divzero();
        logic [63:0] res;
        int rc, sc;
        do_div(1'b0, 32'd5, 32'd0, res, rc, sc);
        total++;
        if (rc !== 2) begin bad++; $display("FAIL divzero_ready_cycle got=%0d exp=2", rc); end
        total++;
        if (sc !== 2) begin bad++; $display("FAIL divzero_stall_cycles got=%0d exp=2", sc); end
        total++;
        if (res !== 64'd0) begin bad++; $display("FAIL divzero_result got=%h exp=0", res); end
        next_cycle();
    endtask

    task automatic test_annul();
        logic [63:0] res;
        logic [63:0] prev;
        int rc, sc, early;
        prev  = bus.result_o;
        early = 0;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd100;
        bus.opdata2_i    = 32'd7;
        bus.start_i      = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            if (c == 10) bus.annul_i = 1'b1;
            #1;
            if (bus.ready_o) early++;
            if (c == 10) begin
                total++;
                if (bus.stallreq_o !== 1'b0) begin bad++; $display("FAIL annul_stall got=%b exp=0", bus.stallreq_o); end
            end
            next_cycle();
        end
        bus.annul_i = 1'b0;
        total++;
        if (early !== 0) begin bad++; $display("FAIL annul_no_ready got=%0d exp=0", early); end
        total++;
        if (bus.result_o !== prev) begin bad++; $display("FAIL annul_result_kept got=%h exp=%h", bus.result_o, prev); end
        do_div(1'b0, 32'd9, 32'd3, res, rc, sc);
        total++;
        if (res !== {32'd0, 32'd3} || rc !== 33) begin
            bad++; $display("FAIL annul_restart got=%h cyc=%0d exp=00000000_00000003 cyc=33", res, rc);
        end
    endtask

    task automatic test_back_to_back();
        int stall_bad, ready_bad;
        stall_bad = 0;
        ready_bad = 0;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd20;
        bus.opdata2_i    = 32'd6;
        bus.start_i      = 1'b1;
        for (int c = 0; c <= 67; c++) begin
            #1;
            if (bus.stallreq_o !== ((c == 33 || c == 67) ? 1'b0 : 1'b1)) stall_bad++;
            if (bus.ready_o !== ((c == 33 || c == 67) ? 1'b1 : 1'b0)) ready_bad++;
            if (c == 33) begin
                total++;
                if (bus.result_o !== {32'd2, 32'd3}) begin bad++; $display("FAIL b2b_first got=%h exp=00000002_00000003", bus.result_o); end
                bus.opdata1_i = 32'd50;
                bus.opdata2_i = 32'd7;
            end
            if (c == 67) begin
                total++;
                if (bus.result_o !== {32'd1, 32'd7}) begin bad++; $display("FAIL b2b_second got=%h exp=00000001_00000007", bus.result_o); end
                bus.start_i = 1'b0;
            end
            next_cycle();
        end
        total++;
        if (stall_bad !== 0) begin bad++; $display("FAIL b2b_stall_pattern wrong_cycles=%0d exp=0", stall_bad); end
        total++;
        if (ready_bad !== 0) begin bad++; $display("FAIL b2b_ready_pattern wrong_cycles=%0d exp=0", ready_bad); end
    endtask

    task automatic test_reset_overflow();
        logic [63:0] res;
        int rc, sc;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd100;
        bus.opdata2_i    = 32'd7;
        bus.start_i      = 1'b1;
        for (int c = 0; c < 15; c++) next_cycle();
        rst = 1'b0;
        next_cycle();
        #1;
        total++;
        if (bus.result_o !== 64'd0) begin bad++; $display("FAIL midop_reset_result got=%h exp=0", bus.result_o); end
        total++;
        if (bus.ready_o !== 1'b0) begin bad++; $display("FAIL midop_reset_ready got=%b exp=0", bus.ready_o); end
        rst         = 1'b1;
        bus.start_i = 1'b0;
        next_cycle();
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, res, rc, sc);
        total++;
        if (rc !== 33) begin bad++; $display("FAIL overflow_ready_cycle got=%0d exp=33", rc); end
        total++;
        if (res !== {32'h0, 32'h8000_0000}) begin bad++; $display("FAIL overflow_result got=%h exp=00000000_80000000", res); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst              = 1'b0;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        next_cycle();
        next_cycle();
        test_reset();
        rst = 1'b1;
        next_cycle();
        test_unsigned();
        test_signed();
        test_divzero();
        test_annul();
        test_back_to_back();
        test_reset_overflow();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
